clk_period_monitor: RTL and testbench
=====================================

Name: clk_period_monitor

Overview:
- Receive-side companion to the on-CPLD clock divider.
- Takes a slow clock (nominal 50 MHz / 2^20, ~47.7 Hz) on `clk_in`, which may be asynchronous or come from off-chip.
- Measures each period in `cpld_50m_clk` cycles and flags out-of-range periods and loss of clock.
- Drives a health indication (`freq_ok`) for board management logic.

Parameters:
- `CNT_W`, 22: width of the period counter and of `period` / `high_time`.
- `MIN_PERIOD`, 1000000: smallest in-range period, inclusive, in `cpld_50m_clk` cycles.
- `MAX_PERIOD`, 1100000: largest in-range period, inclusive.
- `TIMEOUT`, 2097152: cycles without a detected edge before clock-loss is declared. Must be > `MAX_PERIOD` and < 2^`CNT_W`.
- `GOOD_CNT`, 3: consecutive in-range periods required before `freq_ok` asserts.

Ports:
- `cpld_50m_clk`, input, 1: the only clock.
- `cpld_rst_50m`, input, 1: synchronous, active-high reset.
- `clk_in`, input, 1: monitored slow clock, asynchronous to `cpld_50m_clk`.
- `period`, output, `CNT_W`: last measured period, in cycles.
- `period_valid`, output, 1: one-cycle pulse; `period` was updated this cycle.
- `period_err`, output, 1: one-cycle pulse, coincident with `period_valid`, when `period` is out of range.
- `freq_ok`, output, 1: level; `GOOD_CNT` consecutive in-range periods seen and no error/loss since.
- `clk_lost`, output, 1: level; no edge for `TIMEOUT` cycles.
- `high_time`, output, `CNT_W`: cycles `clk_in` was high in the last period. See Optional Feature.

Behaviour:
- Interface rule: one clock (`cpld_50m_clk`). Reset `cpld_rst_50m` is synchronous and active-high.
- Reset values: all outputs 0; state = ACQ; counter and good-run counter 0; synchronizer flops 0.
- Input path: `clk_in` passes a 2-flop synchronizer, then a rising-edge detect (stage2 & ~stage3). A `clk_in` rise sampled at cycle k produces an edge at k+2.
- Outputs are registered. `period_valid` / `period_err` / `period` update on the cycle after the edge (k+3).
- Period value: if edges are detected at cycles t0 and t1, `period` = t1 − t0.
- Counter: restarts at each edge and saturates at `TIMEOUT`; it never wraps.
- States:
  - **ACQ:** waiting for the first edge; nothing reported. Edge → MEAS. Counter reaching `TIMEOUT` → LOST.
  - **MEAS:** every edge reports `period`.
    - In range (`MIN_PERIOD` ≤ p ≤ `MAX_PERIOD`): good-run += 1, saturating at `GOOD_CNT`.
    - Out of range: `period_err` pulses, good-run = 0, `freq_ok` = 0.
    - `freq_ok` = (good-run == `GOOD_CNT`).
    - Counter reaching `TIMEOUT` → LOST.
  - **LOST:** `clk_lost` = 1, `freq_ok` = 0, good-run = 0. Edge → MEAS; `clk_lost` clears next cycle. That edge only restarts timing; no period is reported.
- Simultaneous edge and timeout: the edge wins. The period (= `TIMEOUT`) is reported as out of range, and no LOST is entered.
- Reset mid-operation: outputs clear on the next clock and the state returns to ACQ.
- Spurious edge after reset when `clk_in` is already high: it is absorbed as the ACQ start edge and has no effect on outputs.

Optional Feature:
- Macro: `CLK_MON_DUTY_EN`.
- Defined:
  - A second counter counts cycles where synchronized `clk_in` = 1.
  - Its value is latched into `high_time` together with `period` (same cycle, same `period_valid`), then restarted.
  - It saturates at `TIMEOUT`.
- Not defined: `high_time` is tied to 0 and no duty logic is built. The port list is unchanged in both cases.

Decomposition:
- Package `clk_mon_pkg`:
  - state encoding (ACQ, MEAS, LOST);
  - default constants for `MIN_PERIOD` / `MAX_PERIOD` / `TIMEOUT` / `CNT_W` derived from 50 MHz and the 2^20 divide.
- Sub-module `sync_edge_det`: 2-flop synchronizer plus rising-edge detect, reset to 0.

Test Plan:
All scenarios use overrides `CNT_W`=8, `MIN_PERIOD`=90, `MAX_PERIOD`=110, `TIMEOUT`=200, `GOOD_CNT`=3.
1. Reset, then `clk_in` with period 100 (50 high) ×6 → no report on the 1st edge; `period`=100 with `period_valid` on edges 2–6; `freq_ok` rises at edge 4 (+3 cycles); `clk_lost`=0.
2. Periods 100,100,100,90,110,89,100 → 90 and 110 accepted; 89 pulses `period_err` and drops `freq_ok`; `freq_ok` returns only after 3 further good periods.
3. Steady 100-cycle clock, then hold `clk_in` low → `clk_lost`=1 and `freq_ok`=0 once 200 cycles pass after the last edge; restart → `clk_lost` clears on the first edge with no report, `freq_ok` after 3 more good periods.
4. Assert `cpld_rst_50m` for 1 cycle mid-period with `freq_ok`=1 → all outputs 0 on the next cycle; the next edge is treated as the ACQ start.
5. Period exactly 200 → edge wins: `period`=200 with `period_err`; `clk_lost` stays 0.
6. `CLK_MON_DUTY_EN` defined, period 100 with 30 high → `high_time`=30 coincident with `period_valid`. Undefined → `high_time`=0.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// +----------------------------------------------------------------------------+
// | clk_mon_pkg : shared state encoding and default limits for the clock       |
// |               period monitor                                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package clk_mon_pkg;

   // The monitored clock is the 50 MHz board clock divided by 2^20.
   localparam int unsigned C_REF_HZ       = 50_000_000;
   localparam int unsigned C_DIV_LOG2     = 20;
   localparam int unsigned C_NOM_PERIOD   = 32'd1 << C_DIV_LOG2;
   localparam int unsigned C_MIN_PERIOD   = 1_000_000;
   localparam int unsigned C_MAX_PERIOD   = 1_100_000;
   localparam int unsigned C_TIMEOUT      = 2 * C_NOM_PERIOD;
   localparam int unsigned C_CNT_W        = 22;
   localparam int unsigned C_GOOD_CNT     = 3;

   localparam logic [1:0] ST_ACQ  = 2'd0;
   localparam logic [1:0] ST_MEAS = 2'd1;
   localparam logic [1:0] ST_LOST = 2'd2;

   function automatic logic period_in_range(
      input logic [31:0] p,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      return (p >= lo) && (p <= hi);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// +----------------------------------------------------------------------------+
// | sync_edge_det : two-flop synchronizer followed by a rising-edge detector   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_edge_det
   import clk_mon_pkg::*;
(
   input  logic cpld_50m_clk,
   input  logic cpld_rst_50m,
   input  logic din,
   output logic lvl,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q,  dly_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   always_ff @(posedge cpld_50m_clk) begin
      if (cpld_rst_50m) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign lvl  = sync_q;
   assign rise = sync_q & ~dly_q;

endmodule

`default_nettype wire

// File: rtl/clk_period_monitor.sv
// +----------------------------------------------------------------------------+
// | clk_period_monitor : measures the period of a slow clock, flags range      |
// |                      errors and clock loss. CLK_MON_DUTY_EN adds high time.|
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module clk_period_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W      = C_CNT_W,
   parameter int unsigned MIN_PERIOD = C_MIN_PERIOD,
   parameter int unsigned MAX_PERIOD = C_MAX_PERIOD,
   parameter int unsigned TIMEOUT    = C_TIMEOUT,
   parameter int unsigned GOOD_CNT   = C_GOOD_CNT
) (
   input  logic             cpld_50m_clk,
   input  logic             cpld_rst_50m,
   input  logic             clk_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             period_err,
   output logic             freq_ok,
   output logic             clk_lost,
   output logic [CNT_W-1:0] high_time
);

   localparam int unsigned GW = (GOOD_CNT < 1) ? 1 : $clog2(GOOD_CNT + 1);
   localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(TIMEOUT);
   localparam logic [GW-1:0]    C_GOOD = GW'(GOOD_CNT);

   logic sync_lvl;
   logic rise;

   sync_edge_det u_sync (
      .cpld_50m_clk (cpld_50m_clk),
      .cpld_rst_50m (cpld_rst_50m),
      .din          (clk_in),
      .lvl          (sync_lvl),
      .rise         (rise)
   );

   logic [1:0]       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [GW-1:0]    good_q,     good_d;
   logic [CNT_W-1:0] period_q,   period_d;
   logic             valid_q,    valid_d;
   logic             err_q,      err_d;
   logic             freq_ok_q,  freq_ok_d;
   logic             clk_lost_q, clk_lost_d;
   logic             cnt_sat;
   logic             in_range;

   assign cnt_sat  = (cnt_q == C_TMO);
   assign in_range = period_in_range(32'(cnt_q), MIN_PERIOD, MAX_PERIOD);

   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      period_d   = period_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      freq_ok_d  = freq_ok_q;
      clk_lost_d = clk_lost_q;

      // Counter holds the cycles since the last edge; it pins at the timeout.
      if (rise) begin
         cnt_d = CNT_W'(1);
      end else if (!cnt_sat) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         ST_ACQ: begin
            if (rise) begin
               state_d = ST_MEAS;
            end else if (cnt_sat) begin
               state_d    = ST_LOST;
               clk_lost_d = 1'b1;
               freq_ok_d  = 1'b0;
               good_d     = '0;
            end
         end
         ST_MEAS: begin
            // An edge coinciding with the timeout still counts as a period.
            if (rise) begin
               period_d = cnt_q;
               valid_d  = 1'b1;
               if (in_range) begin
                  good_d = (good_q == C_GOOD) ? good_q : good_q + 1'b1;
               end else begin
                  err_d  = 1'b1;
                  good_d = '0;
               end
               freq_ok_d = (good_d == C_GOOD);
            end else if (cnt_sat) begin
               state_d    = ST_LOST;
               clk_lost_d = 1'b1;
               freq_ok_d  = 1'b0;
               good_d     = '0;
            end
         end
         ST_LOST: begin
            if (rise) begin
               state_d    = ST_MEAS;
               clk_lost_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_ACQ;
         end
      endcase
   end

   always_ff @(posedge cpld_50m_clk) begin
      if (cpld_rst_50m) begin
         state_q    <= ST_ACQ;
         cnt_q      <= '0;
         good_q     <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         freq_ok_q  <= 1'b0;
         clk_lost_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         good_q     <= good_d;
         period_q   <= period_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         freq_ok_q  <= freq_ok_d;
         clk_lost_q <= clk_lost_d;
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign period_err   = err_q;
   assign freq_ok      = freq_ok_q;
   assign clk_lost     = clk_lost_q;

`ifdef CLK_MON_DUTY_EN
   logic [CNT_W-1:0] high_cnt_q,  high_cnt_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;

   // The edge cycle itself is high, so the new count starts from the level.
   always_comb begin
      high_cnt_d  = high_cnt_q;
      high_time_d = high_time_q;
      if (rise) begin
         high_cnt_d = CNT_W'(sync_lvl);
         if (state_q == ST_MEAS) begin
            high_time_d = high_cnt_q;
         end
      end else if (sync_lvl && (high_cnt_q != C_TMO)) begin
         high_cnt_d = high_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge cpld_50m_clk) begin
      if (cpld_rst_50m) begin
         high_cnt_q  <= '0;
         high_time_q <= '0;
      end else begin
         high_cnt_q  <= high_cnt_d;
         high_time_q <= high_time_d;
      end
   end

   assign high_time = high_time_q;
`else
   logic duty_unused;
   assign duty_unused = sync_lvl;
   assign high_time   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_clk_period_monitor : directed and randomized bench with a cycle-level   |
// |                         reference model for clk_period_monitor             |
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_clk_period_monitor;

   localparam int CW   = 8;
   localparam int PMIN = 90;
   localparam int PMAX = 110;
   localparam int TMO  = 200;
   localparam int GC   = 3;
   localparam int MEM  = 65536;

   logic          clk;
   logic          rst;
   logic          clk_in;
   logic [CW-1:0] period;
   logic          period_valid;
   logic          period_err;
   logic          freq_ok;
   logic          clk_lost;
   logic [CW-1:0] high_time;

   clk_period_monitor #(
      .CNT_W      (CW),
      .MIN_PERIOD (PMIN),
      .MAX_PERIOD (PMAX),
      .TIMEOUT    (TMO),
      .GOOD_CNT   (GC)
   ) dut (
      .cpld_50m_clk (clk),
      .cpld_rst_50m (rst),
      .clk_in       (clk_in),
      .period       (period),
      .period_valid (period_valid),
      .period_err   (period_err),
      .freq_ok      (freq_ok),
      .clk_lost     (clk_lost),
      .high_time    (high_time)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: y_hist[n] is clk_in as seen at posedge n (0 under reset).
   // A rise sampled at n is acted on at posedge n+2; a reset inside that
   // window discards it. Period is the distance between acted-on edges.
   bit y_hist [MEM];
   bit r_hist [MEM];
   int cyc    = 0;
   bit m_init = 0;
   int m_state;            // 0 = waiting, 1 = measuring, 2 = lost
   int base;
   int good;
   int e_period, e_valid, e_err, e_ok, e_lost, e_high;

   always @(posedge clk) begin
      bit yn, ed;
      int cnt, hi;
      yn = rst ? 1'b0 : clk_in;
      y_hist[cyc % MEM] = yn;
      r_hist[cyc % MEM] = rst;
      if (rst) begin
         m_init = 1; m_state = 0; base = cyc + 1; good = 0;
         e_period = 0; e_valid = 0; e_err = 0; e_ok = 0; e_lost = 0; e_high = 0;
      end else if (m_init) begin
         ed = (cyc >= 3) && y_hist[(cyc-2) % MEM] && !y_hist[(cyc-3) % MEM]
              && !r_hist[(cyc-1) % MEM];
         cnt = cyc - base;
         if (cnt > TMO) cnt = TMO;
         e_valid = 0;
         e_err   = 0;
         if (ed) begin
            if (m_state == 1) begin
               e_period = cnt;
               e_valid  = 1;
               hi = 0;
               for (int k = base - 2; k < cyc - 2; k++) hi += int'(y_hist[k % MEM]);
`ifdef CLK_MON_DUTY_EN
               e_high = hi;
`else
               e_high = 0;
`endif
               if (cnt >= PMIN && cnt <= PMAX) begin
                  good = (good < GC) ? good + 1 : GC;
               end else begin
                  e_err = 1;
                  good  = 0;
               end
               e_ok = (good == GC) ? 1 : 0;
            end
            m_state = 1;
            e_lost  = 0;
            base    = cyc;
         end else if (cnt == TMO && m_state != 2) begin
            m_state = 2; e_lost = 1; e_ok = 0; good = 0;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("period",       int'(period),       e_period);
         chk("period_valid", int'(period_valid), e_valid);
         chk("period_err",   int'(period_err),   e_err);
         chk("freq_ok",      int'(freq_ok),      e_ok);
         chk("clk_lost",     int'(clk_lost),     e_lost);
         chk("high_time",    int'(high_time),    e_high);
      end
   end

   // Observed report history, used only as the actual side of literal checks.
   int n_valid = 0, n_err = 0, last_p = 0, last_hi = 0, last_err_p = 0;
   always @(negedge clk) begin
      if (period_valid === 1'b1) begin
         n_valid++;
         last_p  = int'(period);
         last_hi = int'(high_time);
         if (period_err === 1'b1) begin
            n_err++;
            last_err_p = int'(period);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int p, input int h);
      clk_in = 1'b1;
      tick(h);
      clk_in = 1'b0;
      tick(p - h);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      int p, h, sel;
      clk_in = 1'b0;
      rst    = 1'b1;
      tick(3);
      chk("reset_period",  int'(period),       0);
      chk("reset_valid",   int'(period_valid), 0);
      chk("reset_freq_ok", int'(freq_ok),      0);
      chk("reset_lost",    int'(clk_lost),     0);
      rst = 1'b0;
      tick(5);

      // Steady nominal clock
      n_valid = 0;
      repeat (6) pulse(100, 50);
      chk("t1_reports", n_valid, 5);
      chk("t1_period",  int'(period), 100);
      chk("t1_freq_ok", int'(freq_ok), 1);
      chk("t1_lost",    int'(clk_lost), 0);

      // Range boundaries and recovery after an error
      n_err = 0;
      pulse(90, 45); pulse(110, 55); pulse(89, 40);
      repeat (4) pulse(100, 50);
      chk("t2_errors",  n_err, 1);
      chk("t2_freq_ok", int'(freq_ok), 1);

      // Clock loss and restart
      clk_in = 1'b0;
      tick(250);
      chk("t3_lost",    int'(clk_lost), 1);
      chk("t3_freq_ok", int'(freq_ok), 0);
      n_valid = 0;
      pulse(100, 50);
      chk("t3_lost_clear",  int'(clk_lost), 0);
      chk("t3_no_report",   n_valid, 0);
      repeat (3) pulse(100, 50);
      chk("t3_reports",  n_valid, 3);
      chk("t3_freq_ok",  int'(freq_ok), 1);

      // Reset mid-period while healthy
      clk_in = 1'b1; tick(50); clk_in = 1'b0; tick(20);
      rst_pulse();
      chk("t4_period",  int'(period),  0);
      chk("t4_freq_ok", int'(freq_ok), 0);
      tick(30);
      n_valid = 0;
      repeat (4) pulse(100, 50);
      chk("t4_reports", n_valid, 3);
      chk("t4_freq_ok", int'(freq_ok), 1);

      // Reset while clk_in is high: the resulting edge becomes the start edge
      clk_in = 1'b1; tick(20);
      rst_pulse();
      tick(40); clk_in = 1'b0; tick(50);
      n_valid = 0;
      repeat (4) pulse(100, 50);
      chk("t4s_reports", n_valid, 4);

      // Edge on the same cycle as the timeout
      n_err = 0;
      pulse(100, 50); pulse(200, 50); pulse(100, 50);
      chk("t5_err_period", last_err_p, 200);
      chk("t5_errors",     n_err, 1);
      chk("t5_lost",       int'(clk_lost), 0);

      // Duty measurement
      repeat (3) pulse(100, 30);
      chk("t6_period", last_p, 100);
`ifdef CLK_MON_DUTY_EN
      chk("t6_high_time", last_hi, 30);
`else
      chk("t6_high_time", last_hi, 0);
`endif

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) p = $urandom_range(195, 215);
         else          p = $urandom_range(80, 120);
         h = $urandom_range(1, p - 1);
         if (sel == 1) begin
            clk_in = 1'b1;
            tick($urandom_range(1, h));
            rst_pulse();
            clk_in = 1'b0;
            tick($urandom_range(1, 60));
         end
         pulse(p, h);
      end
      clk_in = 1'b0;
      tick(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
